// File: rtl/modred_pkg.sv
// ============================================================================
// Module : modred_pkg
// Desc   : Shared constants, stage record and helpers for the modred pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package modred_pkg;

   // Residue widths for the SQIsign level-1/3/5 primes (each P < 2^(W-1))
   localparam int unsigned c_w_l1 = 255;
   localparam int unsigned c_w_l3 = 384;
   localparam int unsigned c_w_l5 = 506;

   localparam int unsigned c_w_max   = 512;
   localparam int unsigned c_vw_max  = 2 * c_w_max;
   localparam int unsigned c_tag_max = 16;

   localparam logic [c_w_l1-1:0] c_p_l1 = (c_w_l1'(5)  << 248) - c_w_l1'(1);
   localparam logic [c_w_l3-1:0] c_p_l3 = (c_w_l3'(65) << 376) - c_w_l3'(1);
   localparam logic [c_w_l5-1:0] c_p_l5 = (c_w_l5'(27) << 500) - c_w_l5'(1);

   // Record carried by every pipeline stage; sized for the largest supported field
   typedef struct packed {
      logic                 valid;
      logic [c_tag_max-1:0] tag;
      logic [c_vw_max-1:0]  val;
   } stage_rec_t;

   function automatic int bit_len(input logic [c_w_max-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < int'(c_w_max); i++) begin
         if (v[i]) n = i + 1;
      end
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/modred_fold.sv
// ============================================================================
// Module : modred_fold
// Desc   : One combinational reduction step: conditional subtracts of P<<k, k=HI..LO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module modred_fold
   import modred_pkg::*;
#(
   parameter int unsigned   W  = c_w_l1,
   parameter logic [W-1:0]  P  = W'(c_p_l1),
   parameter int            HI = 0,
   parameter int            LO = 0
) (
   input  stage_rec_t in_rec,
   output stage_rec_t out_rec
);

   localparam logic [c_vw_max-1:0] c_pw = c_vw_max'(P);

   // Entering step k the value is below P<<(k+1), so one subtract leaves it below P<<k
   always_comb begin
      out_rec = in_rec;
      for (int k = HI; k >= LO; k--) begin
         if (out_rec.val >= (c_pw << k)) begin
            out_rec.val = out_rec.val - (c_pw << k);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/modred_pipe.sv
// ============================================================================
// Module : modred_pipe
// Desc   : Pipelined 2W-bit -> W-bit reduction mod P with valid/ready and tag.
//          MODRED_CANONICAL_EN adds a final stage giving D < P (else D < 2P).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module modred_pipe
   import modred_pkg::*;
#(
   parameter int unsigned  W    = c_w_l1,
   parameter logic [W-1:0] P    = W'(c_p_l1),
   parameter int unsigned  LAT  = 4,
   parameter int unsigned  TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*W-1:0]  A,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    D,
   output logic [TAGW-1:0] out_tag
);

   // Lazy steps k = c_k0 .. 1 spread evenly over LAT+1 registered stages
   localparam int c_pbits = bit_len(c_w_max'(P));
   localparam int c_k0    = 2 * int'(W) - c_pbits;
   localparam int c_nf    = int'(LAT) + 1;
   localparam int c_step  = (c_k0 + c_nf - 1) / c_nf;
`ifdef MODRED_CANONICAL_EN
   localparam int c_ns    = c_nf + 1;
`else
   localparam int c_ns    = c_nf;
`endif

   stage_rec_t r_st   [c_ns];
   stage_rec_t w_fin  [c_ns];
   stage_rec_t w_fout [c_ns];
   logic       w_stall;
   logic       w_unused;

   assign w_stall  = r_st[c_ns-1].valid && !out_ready;
   assign in_ready = !w_stall;

   generate
      for (genvar i = 0; i < c_ns; i++) begin : g_stage
         localparam int c_hi     = (i < c_nf) ? (c_k0 - i * c_step) : 0;
         localparam int c_lo_raw = c_hi - c_step + 1;
         localparam int c_lo     = (i < c_nf) ? ((c_lo_raw < 1) ? 1 : c_lo_raw) : 0;

         if (i == 0) begin : g_head
            assign w_fin[i] = {in_valid, c_tag_max'(in_tag), c_vw_max'(A)};
         end else begin : g_body
            assign w_fin[i] = r_st[i-1];
         end

         modred_fold #(
            .W  (W),
            .P  (P),
            .HI (c_hi),
            .LO (c_lo)
         ) u_fold (
            .in_rec  (w_fin[i]),
            .out_rec (w_fout[i])
         );

         // A stalled output freezes the whole chain, bubbles included
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_st[i] <= '0;
            end else if (!w_stall) begin
               r_st[i] <= w_fout[i];
            end
         end
      end
   endgenerate

   assign out_valid = r_st[c_ns-1].valid;
   assign D         = r_st[c_ns-1].val[W-1:0];
   assign out_tag   = r_st[c_ns-1].tag[TAGW-1:0];

   // Upper value/tag bits of the last stage are zero by construction
   assign w_unused  = ^r_st[c_ns-1];

endmodule

`default_nettype wire

// File: doc/modred_pipe.md
MODRED_PIPE -- requirements
Module: modred_pipe

Interface
REQ-001 SHALL have parameter W, default 255: residue width in bits; input width is 2*W.
REQ-002 SHALL have parameter P, default 5*2^248-1 (SQIsign level-1 prime): modulus, P < 2^(W-1).
REQ-003 SHALL have parameter LAT, default 4: pipeline depth in cycles, range 2..8.
REQ-004 SHALL have parameter TAGW, default 4: width of the sideband tag carried with each operand.
REQ-005 clk  input  1  clock, rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  operand A and in_tag are valid this cycle.
REQ-008 in_ready  output  1  block accepts the operand this cycle.
REQ-009 A  input  2*W  unreduced operand (product of two field elements or any 2W-bit value).
REQ-010 in_tag  input  TAGW  sideband tag, returned unchanged with the result.
REQ-011 out_valid  output  1  D and out_tag are valid.
REQ-012 out_ready  input  1  consumer accepts D this cycle.
REQ-013 D  output  W  reduced result.
REQ-014 out_tag  output  TAGW  tag of the operand that produced D.

Function
REQ-015 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-016 D SHALL be congruent to A mod P for every accepted A; arithmetic is unsigned with no truncation of intermediates.
REQ-017 With no stall, the result of an operand accepted at edge n SHALL be presented with out_valid=1 after edge n+LAT.
REQ-018 Throughput: one operand per cycle when out_ready is held 1.
REQ-019 Stall: out_valid=1 && out_ready=0 SHALL freeze every stage; in_ready = !(out_valid && !out_ready).
REQ-020 While frozen, D, out_tag and out_valid SHALL hold stable; no accepted operand is dropped or duplicated.
REQ-021 Results SHALL leave in acceptance order; each stage carries a valid bit, and bubbles never assert out_valid.
REQ-022 in_valid=0 cycles SHALL insert bubbles; when out_valid=0, D and out_tag are don't-care but SHALL NOT be X after reset.
REQ-023 When the last stage drains (out_ready=1) while a new operand is accepted in the same cycle, both transfers SHALL complete.

Reset
REQ-024 rst=0 SHALL asynchronously clear all stage valid bits; out_valid=0, D=0, out_tag=0 while in reset.
REQ-025 in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight operands; no result for them ever appears.

Configuration
REQ-027 Macro MODRED_CANONICAL_EN defined: an extra final conditional-subtract stage SHALL make D = A mod P, 0 <= D < P; latency becomes LAT+1.
REQ-028 Macro MODRED_CANONICAL_EN undefined: D SHALL be lazy-reduced, 0 <= D < 2P, latency LAT.

Structure
REQ-029 Package modred_pkg SHALL hold the default prime constants (level-1, 3, 5), W defaults and the stage-record typedef (valid, tag, partial value).
REQ-030 The single sub-module modred_fold SHALL implement one combinational folding step; modred_pipe instantiates it per stage and registers its output.

Verification
REQ-031 A=0, tag=3 -> D=0, out_tag=3, out_valid exactly LAT cycles (LAT+1 canonical) after acceptance.
REQ-032 A=P+5 -> canonical D=5; lazy D in {5, P+5}; A=(P-1)^2 -> canonical D=1.
REQ-033 16 random back-to-back operands with out_ready=1 -> one result per cycle, in order, each equal to a golden model mod P (mod P compare in lazy).
REQ-034 Same 16 operands with out_ready toggling pseudo-randomly -> in_ready low exactly during stalls, D stable while stalled, no loss or duplication.
REQ-035 Assert rst=0 with 3 operands in flight -> out_valid=0 immediately; after release, only new operands produce results.
REQ-036 A=2^(2W)-1 (all ones) -> D equals golden (2^(2W)-1) mod P; no overflow in any stage.
